ahbl_lsu_bridge: RTL



---
 rtl/ahbl_lsu_bridge.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahbl_lsu_bridge.sv
// Ibex-style req/gnt/rvalid port to a single AHB-Lite master.
// One beat in address phase and one in data phase at most.
module ahbl_lsu_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          WRITE_EN   = 1'b1,
  parameter logic [3:0]  HPROT      = 4'b0011
) (
  input  logic                  clk_cpu,
  input  logic                  rstn_cpu,
  input  logic                  req_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic                  hmastlock_o,
  output logic [3:0]            hprot_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic                  be_ok;
  logic [2:0]            be_size;
  logic [1:0]            be_off;
  logic                  dp_valid;
  logic                  dp_we;
  logic [DATA_WIDTH-1:0] dp_wdata;
  logic                  lerr_pend;
  logic                  err1;
  logic                  issue;
  logic                  wr_req;
  logic                  dp_done;
  logic                  unused_addr;

  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    be_ok   = 1'b1;
    be_size = 3'b000;
    be_off  = 2'b00;
    unique case (be_i)
      4'b0001: be_off = 2'b00;
      4'b0010: be_off = 2'b01;
      4'b0100: be_off = 2'b10;
      4'b1000: be_off = 2'b11;
      4'b0011: be_size = 3'b001;
      4'b1100: begin
        be_size = 3'b001;
        be_off  = 2'b10;
      end
      4'b1111: be_size = 3'b010;
      default: be_ok = 1'b0;
    endcase
  end

  assign err1    = hresp_i & ~hready_i;
  assign gnt_o   = req_i & hready_i & ~err1 & ~lerr_pend;
  assign issue   = gnt_o & be_ok;
  assign wr_req  = WRITE_EN & we_i;
  assign dp_done = dp_valid & hready_i;

  assign htrans_o = issue ? NONSEQ : IDLE;
  assign haddr_o  = issue ? {addr_i[ADDR_WIDTH-1:2], be_off} : '0;
  assign hsize_o  = issue ? be_size : 3'b000;
  assign hwrite_o = issue & wr_req;

  assign hburst_o    = 3'b000;
  assign hmastlock_o = 1'b0;
  assign hprot_o     = HPROT;
  assign hwdata_o    = dp_wdata;

  // Illegal byte enables answer from lerr_pend, never from the bus.
  assign rvalid_o = lerr_pend | dp_done;
  assign err_o    = lerr_pend | (dp_done & hresp_i);
  assign rdata_o  = (dp_done & ~hresp_i & ~dp_we) ? hrdata_i : '0;

  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      dp_valid  <= 1'b0;
      dp_we     <= 1'b0;
      dp_wdata  <= '0;
      lerr_pend <= 1'b0;
    end else begin
      lerr_pend <= gnt_o & ~be_ok;
      if (gnt_o) begin
        dp_valid <= be_ok;
        dp_we    <= wr_req;
      end else if (hready_i) begin
        dp_valid <= 1'b0;
      end
      if (gnt_o & wr_req) begin
        dp_wdata <= wdata_i;
      end
    end
  end

endmodule
